// File: rtl/hex_counter_ctrl.sv
// hex_counter_ctrl: single-digit 7-segment counter controller.
//   Debounces the run (iSW0) and direction (iSW1) switches, generates the count
//   tick from a programmable prescaler, holds the digit and drives the segments.
//   A small register slave port (read latency 1) lets software override the
//   switches, set the tick period, load the digit and read status.
// Ports:
//   iCLK_50, iRST_n          clock, async active-low reset (released synchronously)
//   iSW0, iSW1               raw run / direction switches
//   iWR, iRD, iADDR, iWDATA  slave write/read strobes, address, write data
//   oRDATA                   registered read data, valid the cycle after iRD
//   oDIGIT, oHEX             current digit and its active-low segment pattern
//   oTICK, oWRAP             one-cycle pulses per count step / per wrap

// Per-switch debouncer: 2-FF synchronizer plus a stability counter. The output
// follows the synchronized input only after it has differed for DEBOUNCE_CYCLES
// consecutive cycles; any bounce back restarts the count.
module hex_counter_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstN,
  input  logic raw,
  output logic db
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       syncPipe;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncPipe <= '0;
      cnt      <= '0;
      db       <= 1'b0;
    end else begin
      syncPipe <= {syncPipe[0], raw};
      if (syncPipe[1] == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        db  <= syncPipe[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module hex_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PERIOD_W        = 26,
  parameter int PERIOD_RST      = 49999999,
  parameter int MAX_DIGIT       = 9
) (
  input  logic        iCLK_50,
  input  logic        iRST_n,
  input  logic        iSW0,
  input  logic        iSW1,
  input  logic        iWR,
  input  logic        iRD,
  input  logic [1:0]  iADDR,
  input  logic [31:0] iWDATA,
  output logic [31:0] oRDATA,
  output logic [3:0]  oDIGIT,
  output logic [6:0]  oHEX,
  output logic        oTICK,
  output logic        oWRAP
);
  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0]          MAX_D   = 4'(MAX_DIGIT);
  localparam logic [PERIOD_W-1:0] PER_RST = PERIOD_W'(PERIOD_RST);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rstPipe;
  logic       rstN;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) rstPipe <= '0;
    else         rstPipe <= {rstPipe[0], 1'b1};
  end
  assign rstN = rstPipe[1];

  // Switch debouncing, one instance per switch.
  logic [1:0] swRaw;
  logic [1:0] swDb;
  assign swRaw = {iSW1, iSW0};

  for (genvar g = 0; g < 2; g++) begin : gDb
    hex_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDb (
      .clk  (iCLK_50),
      .rstN (rstN),
      .raw  (swRaw[g]),
      .db   (swDb[g])
    );
  end

  // Registers and state.
  logic [2:0]          ctrl;      // {UP_SW, RUN_SW, SW_OVR}
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] presc;
  logic [3:0]          digit;
  logic [0:0]          state;

  logic runEff, upEff;
  assign runEff = ctrl[0] ? ctrl[1] : swDb[0];
  assign upEff  = ctrl[0] ? ctrl[2] : swDb[1];

  logic wrCtrl, wrPeriod, wrDigit, wrLoad;
  assign wrCtrl   = iWR && (iADDR == 2'd0);
  assign wrPeriod = iWR && (iADDR == 2'd1);
  assign wrDigit  = iWR && (iADDR == 2'd2);
  assign wrLoad   = wrPeriod || wrDigit;

  // A PERIOD/DIGIT write in the tick cycle wins: the tick is dropped.
  logic prescEnd, tickDue, wrapDue;
  assign prescEnd = (presc == period);
  assign tickDue  = (state == ST_RUN) && runEff && prescEnd && !wrLoad;
  assign wrapDue  = upEff ? (digit >= MAX_D) : (digit == 4'd0);

  logic [3:0] digitStep, digitLoad;
  assign digitStep = upEff ? (wrapDue ? 4'd0  : digit + 4'd1)
                           : (wrapDue ? MAX_D : digit - 4'd1);
  assign digitLoad = (iWDATA[3:0] > MAX_D) ? MAX_D : iWDATA[3:0];

  logic [PERIOD_W-1:0] periodLoad;
  assign periodLoad = (iWDATA[PERIOD_W-1:0] == '0) ? PERIOD_W'(1) : iWDATA[PERIOD_W-1:0];

  // Bits of iWDATA above the widest field are intentionally ignored.
  logic unusedWdata;
  assign unusedWdata = ^iWDATA;

  always_ff @(posedge iCLK_50 or negedge rstN) begin
    if (!rstN) begin
      ctrl   <= '0;
      period <= PER_RST;
      presc  <= '0;
      digit  <= '0;
      state  <= ST_STOP;
      oTICK  <= 1'b0;
      oWRAP  <= 1'b0;
    end else begin
      if (wrCtrl)   ctrl   <= iWDATA[2:0];
      if (wrPeriod) period <= periodLoad;

      case (state)
        ST_STOP: if (runEff)  state <= ST_RUN;
        default: if (!runEff) state <= ST_STOP;
      endcase

      // Prescaler only advances while running; every stop/start, load or
      // terminal count restarts the period. Direction changes leave it alone.
      if (wrLoad || (state == ST_STOP) || !runEff || prescEnd) presc <= '0;
      else                                                      presc <= presc + PERIOD_W'(1);

      if (wrDigit)      digit <= digitLoad;
      else if (tickDue) digit <= digitStep;

      oTICK <= tickDue;
      oWRAP <= tickDue && wrapDue;
    end
  end

  // Read path: registered, updated only on iRD.
  logic [31:0] rdMux;
  always_comb begin
    rdMux = '0;
    case (iADDR)
      2'd0:    rdMux = {29'd0, ctrl};
      2'd1:    rdMux = 32'(period);
      2'd2:    rdMux = {28'd0, digit};
      default: rdMux = {24'd0, digit, swDb[1], swDb[0], upEff, runEff};
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge rstN) begin
    if (!rstN)    oRDATA <= '0;
    else if (iRD) oRDATA <= rdMux;
  end

  assign oDIGIT = digit;

  // Active-low segments, bit0 = a ... bit6 = g.
  always_comb begin
    oHEX = 7'b1111111;
    case (digit)
      4'h0: oHEX = 7'b1000000;
      4'h1: oHEX = 7'b1111001;
      4'h2: oHEX = 7'b0100100;
      4'h3: oHEX = 7'b0110000;
      4'h4: oHEX = 7'b0011001;
      4'h5: oHEX = 7'b0010010;
      4'h6: oHEX = 7'b0000010;
      4'h7: oHEX = 7'b1111000;
      4'h8: oHEX = 7'b0000000;
      4'h9: oHEX = 7'b0010000;
      4'hA: oHEX = 7'b0001000;
      4'hB: oHEX = 7'b0000011;
      4'hC: oHEX = 7'b1000110;
      4'hD: oHEX = 7'b0100001;
      4'hE: oHEX = 7'b0000110;
      default: oHEX = 7'b0001110;
    endcase
  end
endmodule

// File: doc/hex_counter_ctrl.md
Name: hex_counter_ctrl

Overview:
Controller and sequencer for the single-digit 7-segment counter on the board. Debounces iSW0 (run/stop) and iSW1 (direction), and generates the count tick from a programmable prescaler. Holds the digit register and drives the segment outputs. A small Nios II slave port (read latency 1) lets software override the switches, set the tick period, load the digit and read status.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles (20 ms at 50 MHz) before a debounced switch changes
PERIOD_W, 26, prescaler/period register width
PERIOD_RST, 49999999, reset value of PERIOD (1 Hz tick at 50 MHz)
MAX_DIGIT, 9, highest digit value before wrap (1..15)

Ports:
iCLK_50  in  1  system clock, 50 MHz
iRST_n  in  1  asynchronous active-low reset
iSW0  in  1  raw run switch (1 = run)
iSW1  in  1  raw direction switch (1 = up)
iWR  in  1  slave write strobe, single cycle
iRD  in  1  slave read strobe, single cycle
iADDR  in  2  register address
iWDATA  in  32  write data
oRDATA  out  32  read data, valid the cycle after iRD
oDIGIT  out  4  current digit
oHEX  out  7  segment drive for oDIGIT, active-low, bit0 = segment a
oTICK  out  1  one-cycle pulse per count step
oWRAP  out  1  one-cycle pulse when the digit wraps

Behaviour:
- Reset (async assert, sync release): digit=0, PERIOD=PERIOD_RST, CTRL=0, prescaler=0, FSM=STOP, debounced switches=0, debounce counters=0, oTICK=oWRAP=0, oRDATA=0, oHEX=7'b1000000.
- Switch path: 2-FF synchronizer, then a per-switch counter. The debounced value takes the synchronized value after it differs for DEBOUNCE_CYCLES consecutive cycles. Any bounce back clears the counter.
- Effective controls: run_eff = CTRL[0] ? CTRL[1] : sw0_db; up_eff = CTRL[0] ? CTRL[2] : sw1_db.
- FSM:
  - STOP -> RUN when run_eff=1; prescaler cleared on entry.
  - RUN -> STOP when run_eff=0; prescaler cleared; digit holds.
- In RUN, prescaler increments every cycle. When prescaler==PERIOD:
  - prescaler<=0 and oTICK<=1 on that edge.
  - Digit steps by ±1 per up_eff on the same edge.
  - So ticks are PERIOD+1 cycles apart, and the first tick comes PERIOD+1 cycles after entering RUN.
- Wrap: up at MAX_DIGIT -> 0; down at 0 -> MAX_DIGIT. oWRAP pulses in the same cycle as the oTICK of that step.
- Registers (write on the iWR cycle):
  - addr0 CTRL[2:0]: bit0 SW_OVR, bit1 RUN_SW, bit2 UP_SW. Other bits read 0.
  - addr1 PERIOD[PERIOD_W-1:0]: a written value of 0 is stored as 1. Any write clears the prescaler.
  - addr2 DIGIT: loads iWDATA[3:0]. Values > MAX_DIGIT are stored as MAX_DIGIT. The load clears the prescaler.
  - addr3 STATUS: read-only; writes ignored. bit0 run_eff, bit1 up_eff, bit2 sw0_db, bit3 sw1_db, bits[7:4] digit.
- Write vs tick in the same cycle: any write to PERIOD or DIGIT suppresses that cycle's tick. No oTICK/oWRAP is emitted, and the loaded value wins.
- Direction change mid-period: takes effect at the next tick; the prescaler is not reset.
- oRDATA: registered, updated only on iRD. It holds the last value otherwise; unused bits read 0.
- oHEX: combinational decode of oDIGIT for 0-F.
- Reset mid-count: all state returns to reset values immediately, with no pulse emitted.

Test Plan:
DEBOUNCE_CYCLES=4 and PERIOD written to 3 throughout.
1. Reset, then write CTRL=0b011 (override, run, down) -> first oTICK 4 cycles after RUN entry; digit 0->9 with oWRAP=1; then 8, 7 every 4 cycles.
2. iSW0 pulses high 3 cycles, then iSW1=1 and iSW0=1 held -> no run after the short pulse; run_eff=1 6 cycles after iSW0 rises (2 sync + 4 stable); digit counts up 0,1,2...
3. Count up from 7 -> 8, 9, 0; oWRAP pulses exactly at 9->0; oHEX=7'b1000000 at 0 and 7'b0010000 at 9.
4. Write DIGIT=12 in the same cycle a tick is due -> digit=9, no oTICK that cycle, next tick 4 cycles later gives 0 with oWRAP.
5. Write PERIOD=0, then read addr1 -> oRDATA=1 one cycle after iRD; ticks every 2 cycles.
6. Assert iRST_n=0 mid-period with digit=5 -> digit=0, oTICK=0 and FSM=STOP immediately; after release, PERIOD reads 49999999.
